// File: rtl/sb_tx_arbiter.sv
// sb_tx_arbiter
//   Round-robin arbiter that funnels sideband messages from N_REQ LTSM
//   substate requesters into a single sideband TX port. A grant is held
//   until the TX side acknowledges it or TIMEOUT_CYCLES elapse. Every grant
//   is followed by a one-cycle DONE state, so grants are at least three
//   cycles apart.
//
// Handshake (both sides):
//   Requester i raises req_valid_i[i] with req_msg_i[i] and holds it until
//   req_ack_o[i] or timeout_o pulses. The arbiter raises TX_msg_valid_o with
//   a stable TX_msg_o and holds both until TX_msg_valid_ack_i is seen in the
//   same cycle (transfer), or the grant times out. Acks outside a grant are
//   ignored.
//
// Ports:
//   clk_100MHz          in   sole clock, rising edge
//   reset_n             in   asynchronous active-low reset
//   req_msg_i           in   N_REQ*MSG_W, message of requester i at [i*MSG_W +: MSG_W]
//   req_valid_i         in   N_REQ, per-requester valid
//   req_ack_o           out  N_REQ, one-cycle accept pulse
//   TX_msg_o            out  MSG_W, registered message toward sideband TX
//   TX_msg_valid_o      out  registered valid toward sideband TX
//   TX_msg_valid_ack_i  in   sideband TX acceptance
//   grant_id_o          out  index of current or last granted requester
//   busy_o              out  high in GRANT and DONE
//   timeout_o           out  one-cycle pulse when a grant is dropped
//   state_dbg           out  FSM state (0 IDLE, 1 GRANT, 2 DONE)

module sb_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 800000,
    parameter int MSG_W          = 64
) (
    input  logic                       clk_100MHz,
    input  logic                       reset_n,
    input  logic [N_REQ*MSG_W-1:0]     req_msg_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    output logic [N_REQ-1:0]           req_ack_o,
    output logic [MSG_W-1:0]           TX_msg_o,
    output logic                       TX_msg_valid_o,
    input  logic                       TX_msg_valid_ack_i,
    output logic [$clog2(N_REQ)-1:0]   grant_id_o,
    output logic                       busy_o,
    output logic                       timeout_o,
    output logic [1:0]                 state_dbg
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ID_W:0]    N_REQ_W  = (ID_W+1)'(N_REQ);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_next;
    logic [CNT_W-1:0] tmo_cnt;

    logic             any_req;
    logic [ID_W-1:0]  winner;
    logic [MSG_W-1:0] win_msg;
    logic             do_grant;
    logic             do_ack;
    logic             do_timeout;

    // Round-robin search: the valid vector is doubled so that scanning
    // offsets 0..N_REQ-1 from rr_ptr never needs a modulo. Scanning from
    // the highest offset down lets the lowest offset overwrite, so the
    // requester closest to rr_ptr wins.
    logic [2*N_REQ-1:0] req_dbl;
    logic [ID_W:0]      pos;
    logic [ID_W:0]      win_pos;

    always_comb begin
        req_dbl = {req_valid_i, req_valid_i};
        any_req = 1'b0;
        win_pos = '0;
        pos     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            pos = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (req_dbl[pos]) begin
                any_req = 1'b1;
                win_pos = pos;
            end
        end
        if (win_pos >= N_REQ_W) begin
            winner = ID_W'(win_pos - N_REQ_W);
        end else begin
            winner = win_pos[ID_W-1:0];
        end
    end

    always_comb begin
        win_msg = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == winner) begin
                win_msg = req_msg_i[i*MSG_W +: MSG_W];
            end
        end
    end

    // The granted requester drops to lowest priority once its grant ends.
    logic [ID_W:0] gid_inc;
    assign gid_inc = {1'b0, grant_id_o} + (ID_W+1)'(1);
    assign rr_next = (gid_inc == N_REQ_W) ? '0 : gid_inc[ID_W-1:0];

    // FSM state register
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and control strobes. Ack is tested before the timeout
    // so that an ack arriving in the last counted cycle still completes.
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_ack     = 1'b0;
        do_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    do_grant   = 1'b1;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (TX_msg_valid_ack_i) begin
                    do_ack     = 1'b1;
                    state_next = ST_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    do_timeout = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr         <= '0;
            tmo_cnt        <= '0;
            TX_msg_o       <= '0;
            TX_msg_valid_o <= 1'b0;
            grant_id_o     <= '0;
            req_ack_o      <= '0;
            timeout_o      <= 1'b0;
        end else begin
            req_ack_o <= '0;
            timeout_o <= 1'b0;
            if (do_grant) begin
                TX_msg_o       <= win_msg;
                grant_id_o     <= winner;
                TX_msg_valid_o <= 1'b1;
                tmo_cnt        <= '0;
            end else if (state == ST_GRANT) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (do_ack || do_timeout) begin
                TX_msg_valid_o <= 1'b0;
                rr_ptr         <= rr_next;
            end
            if (do_ack) begin
                req_ack_o <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_o;
            end
            if (do_timeout) begin
                timeout_o <= 1'b1;
            end
        end
    end

    assign busy_o    = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: doc/sb_tx_arbiter.md
SB_TX_ARBITER -- requirements
Module: sb_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of LTSM substate requesters (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 800000: cycles to wait for ack before dropping a grant (8 ms at 100 MHz).
REQ-003 clk_100MHz  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_msg_i  input  N_REQ x SB_msg_t  per-requester sideband message.
REQ-006 req_valid_i  input  N_REQ  per-requester message valid; held high until req_ack_o or timeout_o for that requester.
REQ-007 req_ack_o  output  N_REQ  one-cycle pulse: message accepted by sideband TX.
REQ-008 TX_msg_o  output  SB_msg_t  registered message to sideband TX.
REQ-009 TX_msg_valid_o  output  1  registered valid toward sideband TX.
REQ-010 TX_msg_valid_ack_i  input  1  sideband TX acceptance of TX_msg_o.
REQ-011 grant_id_o  output  $clog2(N_REQ)  index of current or last granted requester.
REQ-012 busy_o  output  1  high in GRANT and DONE states.
REQ-013 timeout_o  output  1  one-cycle pulse when a grant is dropped for lack of ack.

Function
REQ-014 FSM states: IDLE, GRANT, DONE.
REQ-015 IDLE: if any req_valid_i bit is high, select the winner round-robin starting at index rr_ptr, then rr_ptr+1, and so on, wrapping at N_REQ-1 -> 0.
REQ-016 On selection, latch req_msg_i[winner] into TX_msg_o, set grant_id_o=winner and TX_msg_valid_o=1, and go to GRANT; TX_msg_valid_o rises on the edge after req_valid_i is sampled (1-cycle latency).
REQ-017 GRANT: TX_msg_o and grant_id_o stay stable; the requester's later changes to req_msg_i or req_valid_i are ignored.
REQ-018 GRANT with TX_msg_valid_ack_i=1: next edge clears TX_msg_valid_o, pulses req_ack_o[grant_id_o] for one cycle, sets rr_ptr=(grant_id_o+1) mod N_REQ, and goes to DONE.
REQ-019 DONE: lasts exactly one cycle, then goes to IDLE; no arbitration occurs, so consecutive grants are at least 3 cycles apart.
REQ-020 Timeout counter: cleared on entry to GRANT, incremented each GRANT cycle without ack.
REQ-021 Timeout expiry: at count TIMEOUT_CYCLES-1 without ack, next edge clears TX_msg_valid_o, pulses timeout_o, does not pulse req_ack_o, sets rr_ptr=(grant_id_o+1) mod N_REQ, and goes to DONE.
REQ-022 Ack and timeout expiry in the same cycle: ack wins; req_ack_o pulses and timeout_o stays low.
REQ-023 TX_msg_valid_ack_i outside GRANT is ignored.
REQ-024 At most one req_ack_o bit is high in any cycle; req_ack_o and timeout_o are never high together.
REQ-025 A requester still valid after a timeout is re-arbitrated normally, now at lowest priority.
REQ-026 No requests in IDLE: the FSM stays in IDLE and all outputs hold their idle values.

Reset
REQ-027 reset_n low asynchronously forces: state=IDLE, rr_ptr=0, TX_msg_valid_o=0, TX_msg_o=0, req_ack_o=0, grant_id_o=0, busy_o=0, timeout_o=0, counter=0.
REQ-028 Reset asserted mid-GRANT drops the message: no ack or timeout pulse is produced, and arbitration restarts at index 0 after release.
REQ-029 First arbitration occurs on the first rising edge with reset_n high.

Verification
REQ-030 Single request: req_valid_i=4'b0100 with ack returned 2 cycles after valid -> TX_msg_valid_o high the next cycle, TX_msg_o=req_msg_i[2], grant_id_o=2, req_ack_o=4'b0100 for 1 cycle, busy_o low 2 cycles after ack.
REQ-031 Round-robin: req_valid_i=4'b1111 held, each granted request acked 1 cycle after TX_msg_valid_o -> grant order 0,1,2,3,0.
REQ-032 Timeout with TIMEOUT_CYCLES=10: request 1, ack never asserted -> TX_msg_valid_o high for exactly 10 cycles, timeout_o pulses once, req_ack_o stays 0, and request 1 is re-granted after DONE if still valid.
REQ-033 Simultaneous events, TIMEOUT_CYCLES=10: ack asserted in the 10th GRANT cycle -> req_ack_o pulses and timeout_o=0.
REQ-034 Message stability: req_msg_i[0] changed during GRANT -> TX_msg_o keeps the latched value until ack.
REQ-035 Reset mid-GRANT: reset_n low for 1 cycle during GRANT -> all outputs 0 immediately, with no req_ack_o or timeout_o pulse.
